// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - fully-associative write-back data cache with age-based replacement
//
// Purpose: a fully-associative cache of WAYS lines, each LINEWORDS words long.
// Hits are answered one cycle after acceptance. A miss writes back a dirty victim
// (FLUSH), loads the new line (FILL), and then performs the captured access as a hit
// (REPLAY).
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cpu_addr/cpu_in            request byte address and right-aligned write data
//   cpu_rdreq/cpu_wrreq        request strobes (both high means write)
//   cpu_wordlen                00 byte, 01 half, 10 word, 11 illegal
//   cpu_out/cpu_out_valid      right-aligned, zero-extended read data and its strobe
//   cpu_busy                   high while a miss is being serviced
//   cpu_err                    one-cycle pulse for a misaligned or illegal request
//   mem_addr/mem_in/mem_wrreq  line write-back, one word per mem_wrack
//   mem_rdreq/mem_out(_valid)  line fill, one word per mem_out_valid
//   cnt_hit/cnt_miss           hit/miss counters
//
// Optional feature: define DCACHE_ASSOC_PERFCNT_EN to build the hit/miss counters;
// without it, both counter outputs are tied to zero.
module dcache_assoc #(
  parameter int DATABITS  = 32,
  parameter int ADDRBITS  = 32,
  parameter int WAYS      = 4,
  parameter int LINEWORDS = 8,
  parameter int TTLBITS   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDRBITS-1:0] cpu_addr,
  input  logic [DATABITS-1:0] cpu_in,
  input  logic                cpu_rdreq,
  input  logic                cpu_wrreq,
  input  logic [1:0]          cpu_wordlen,
  output logic [DATABITS-1:0] cpu_out,
  output logic                cpu_out_valid,
  output logic                cpu_busy,
  output logic                cpu_err,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic [DATABITS-1:0] mem_in,
  input  logic [DATABITS-1:0] mem_out,
  input  logic                mem_out_valid,
  output logic                mem_rdreq,
  output logic                mem_wrreq,
  input  logic                mem_wrack,
  output logic [31:0]         cnt_hit,
  output logic [31:0]         cnt_miss
);

  localparam int WIDXB = $clog2(LINEWORDS);
  localparam int OFFB  = WIDXB + 2;
  localparam int TAGB  = ADDRBITS - OFFB;
  localparam int WAYB  = $clog2(WAYS);
  localparam int NB    = DATABITS / 8;
  localparam logic [TTLBITS-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {IDLE, FLUSH, FILL, REPLAY} state_t;
  state_t state, state_n;

  logic [TAGB-1:0]     tags  [WAYS];
  logic [TTLBITS-1:0]  age   [WAYS];
  logic [DATABITS-1:0] lines [WAYS][LINEWORDS];
  logic [WAYS-1:0]     valid, dirty;

  // Miss request captured at acceptance, replayed after the fill.
  logic [ADDRBITS-1:0] req_addr;
  logic [DATABITS-1:0] req_data;
  logic [1:0]          req_len;
  logic                req_wr;
  logic [WAYB-1:0]     vict_way;
  logic [WIDXB-1:0]    word_cnt;
  logic                last_word;

  function automatic logic is_legal(input logic [1:0] len, input logic [1:0] off);
    case (len)
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      2'b10:   return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [NB-1:0] be_of(input logic [1:0] len, input logic [1:0] off);
    logic [NB-1:0] m;
    case (len)
      2'b00:   m = NB'(1);
      2'b01:   m = NB'(3);
      default: m = NB'(15);
    endcase
    return m << off;
  endfunction

  // Request decode in IDLE
  logic accept, legal_in, hit, miss_go, illegal;
  logic [WAYB-1:0] hit_way, vict_n;
  logic [TTLBITS-1:0] best_age;
  logic found_inv;

  assign accept    = (state == IDLE) && (cpu_rdreq || cpu_wrreq);
  assign legal_in  = is_legal(cpu_wordlen, cpu_addr[1:0]);
  assign miss_go   = accept && legal_in && !hit;
  assign illegal   = accept && !legal_in;
  assign cpu_busy  = (state != IDLE);
  assign last_word = (word_cnt == WIDXB'(LINEWORDS - 1));

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[w] && (tags[w] == cpu_addr[ADDRBITS-1:OFFB])) begin
        hit     = 1'b1;
        hit_way = WAYB'(w);
      end
    end
  end

  // Victim: first invalid way, otherwise oldest way (strict > keeps the lowest index on ties).
  always_comb begin
    vict_n    = '0;
    found_inv = 1'b0;
    best_age  = age[0];
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid[w]) begin
        vict_n    = WAYB'(w);
        found_inv = 1'b1;
      end
    end
    if (!found_inv) begin
      for (int w = 1; w < WAYS; w++) begin
        if (age[w] > best_age) begin
          best_age = age[w];
          vict_n   = WAYB'(w);
        end
      end
    end
  end

  // Shared access path: a hit from IDLE or the replay of a captured miss.
  logic                acc_en, acc_wr;
  logic [WAYB-1:0]     acc_way;
  logic [ADDRBITS-1:0] acc_addr;
  logic [DATABITS-1:0] acc_data, acc_word, wdata_sh, rd_sh, rd_val, merged;
  logic [1:0]          acc_len, acc_off;
  logic [WIDXB-1:0]    acc_widx;
  logic [NB-1:0]       acc_be;

  assign acc_en   = (state == REPLAY) || (accept && legal_in && hit);
  assign acc_way  = (state == REPLAY) ? vict_way : hit_way;
  assign acc_addr = (state == REPLAY) ? req_addr : cpu_addr;
  assign acc_data = (state == REPLAY) ? req_data : cpu_in;
  assign acc_len  = (state == REPLAY) ? req_len  : cpu_wordlen;
  assign acc_wr   = (state == REPLAY) ? req_wr   : cpu_wrreq;
  assign acc_off  = acc_addr[1:0];
  assign acc_widx = acc_addr[OFFB-1:2];
  assign acc_word = lines[acc_way][acc_widx];
  assign acc_be   = be_of(acc_len, acc_off);
  assign rd_sh    = acc_word >> {acc_off, 3'b000};
  assign wdata_sh = acc_data << {acc_off, 3'b000};

  always_comb begin
    case (acc_len)
      2'b00:   rd_val = rd_sh & DATABITS'(32'h0000_00FF);
      2'b01:   rd_val = rd_sh & DATABITS'(32'h0000_FFFF);
      default: rd_val = rd_sh;
    endcase
  end

  always_comb begin
    merged = acc_word;
    for (int b = 0; b < NB; b++) begin
      if (acc_be[b]) merged[8*b +: 8] = wdata_sh[8*b +: 8];
    end
  end

  // FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mem_rdreq = 1'b0;
    mem_wrreq = 1'b0;
    mem_addr  = '0;
    mem_in    = '0;
    case (state)
      IDLE: begin
        if (miss_go) state_n = (valid[vict_n] && dirty[vict_n]) ? FLUSH : FILL;
      end
      FLUSH: begin
        mem_wrreq = 1'b1;
        mem_addr  = {tags[vict_way], word_cnt, 2'b00};
        mem_in    = lines[vict_way][word_cnt];
        if (mem_wrack && last_word) state_n = FILL;
      end
      FILL: begin
        mem_rdreq = 1'b1;
        mem_addr  = {req_addr[ADDRBITS-1:OFFB], OFFB'(0)};
        if (mem_out_valid && last_word) state_n = REPLAY;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state and CPU response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid         <= '0;
      dirty         <= '0;
      for (int w = 0; w < WAYS; w++) age[w] <= '0;
      word_cnt      <= '0;
      vict_way      <= '0;
      req_addr      <= '0;
      req_data      <= '0;
      req_len       <= '0;
      req_wr        <= 1'b0;
      cpu_out       <= '0;
      cpu_out_valid <= 1'b0;
      cpu_err       <= 1'b0;
    end else begin
      cpu_out       <= '0;
      cpu_out_valid <= 1'b0;
      cpu_err       <= illegal;
      if (miss_go) begin
        req_addr <= cpu_addr;
        req_data <= cpu_in;
        req_len  <= cpu_wordlen;
        req_wr   <= cpu_wrreq;
        vict_way <= vict_n;
        word_cnt <= '0;
      end
      if (state == FLUSH && mem_wrack) word_cnt <= word_cnt + 1'b1;
      if (state == FILL && mem_out_valid) begin
        word_cnt <= word_cnt + 1'b1;
        if (last_word) begin
          valid[vict_way] <= 1'b1;
          dirty[vict_way] <= 1'b0;
          age[vict_way]   <= '0;
        end
      end
      if (acc_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAYB'(w) == acc_way)                  age[w] <= '0;
          else if (valid[w] && age[w] != AGE_MAX)   age[w] <= age[w] + 1'b1;
        end
        if (acc_wr) begin
          dirty[acc_way] <= 1'b1;
        end else begin
          cpu_out_valid <= 1'b1;
          cpu_out       <= rd_val;
        end
      end
    end
  end

  // Line data and tags survive reset; valid bits alone decide their meaning.
  always_ff @(posedge clk) begin
    if (state == FILL && mem_out_valid) begin
      lines[vict_way][word_cnt] <= mem_out;
      if (last_word) tags[vict_way] <= req_addr[ADDRBITS-1:OFFB];
    end
    if (acc_en && acc_wr) lines[acc_way][acc_widx] <= merged;
  end

`ifdef DCACHE_ASSOC_PERFCNT_EN
  logic [31:0] hit_q, miss_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (accept && legal_in && hit) hit_q <= hit_q + 1'b1;
      if (miss_go) miss_q <= miss_q + 1'b1;
    end
  end
  assign cnt_hit  = hit_q;
  assign cnt_miss = miss_q;
`else
  assign cnt_hit  = '0;
  assign cnt_miss = '0;
`endif

endmodule
